rabbit_next_state: RTL
======================

Name: rabbit_next_state

Overview:
- Rabbit keystream next-state stage. Sits directly downstream of the counter-update block and consumes its updated counters C0..C7.
- Computes the eight g-values g_j = LSW(u^2) XOR MSW(u^2), where u = (X_j + C_j) mod 2^32.
- Combines the g-values into the new state words X0..X7.
- Time-multiplexes a small number of squarer units over several cycles, with valid/ready handshakes on both sides.

Parameters:
- NUM_G_UNITS, 1, g-units instantiated and g-values computed per cycle. Legal values: 1, 2, 4, 8; any other value is an elaboration error.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  x_in/c_in valid
- in_ready  output  1  block can accept a new state
- x_in  input  256  current X words; word j at [32j+31:32j]
- c_in  input  256  updated counters from the counter-update stage; same packing
- out_valid  output  1  x_out holds a new state
- out_ready  input  1  consumer accepts x_out
- x_out  output  256  next X words; same packing
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: state=IDLE, x_out=0, out_valid=0, in_ready=1, busy=0, internal g registers and index cleared.
- Reset mid-operation aborts the computation; no partial output is ever presented.
- in_ready=1 only in IDLE. in_valid is ignored in every other state.
- IDLE: on in_valid & in_ready, latch x_in and c_in, clear idx, go to G_CALC.
- G_CALC: each cycle compute g for words idx .. idx+NUM_G_UNITS-1 and store them in g regs.
  - idx += NUM_G_UNITS.
  - After the cycle that stores g7, go to COMBINE.
  - Cycle count is 8/NUM_G_UNITS.
- g arithmetic:
  - u = (x_j + c_j) mod 2^32; the carry out is discarded.
  - s = u*u, full 64 bits.
  - g = s[31:0] ^ s[63:32].
- COMBINE: one cycle; register all eight x_out words, set out_valid=1, go to DONE. All sums mod 2^32; rotl = 32-bit rotate left.
  - x0 = g0 + rotl(g7,16) + rotl(g6,16)
  - x1 = g1 + rotl(g0,8) + g7
  - x2 = g2 + rotl(g1,16) + rotl(g0,16)
  - x3 = g3 + rotl(g2,8) + g1
  - x4 = g4 + rotl(g3,16) + rotl(g2,16)
  - x5 = g5 + rotl(g4,8) + g3
  - x6 = g6 + rotl(g5,16) + rotl(g4,16)
  - x7 = g7 + rotl(g6,8) + g5
- DONE: hold out_valid=1 and x_out stable until out_ready=1. On that edge, out_valid goes to 0 and state goes to IDLE.
  - x_out keeps its value until the next COMBINE.
  - out_ready while out_valid=0 has no effect.
- Latency: if the accept is at edge N, out_valid rises at edge N + 8/NUM_G_UNITS + 1 (edge N+9 for NUM_G_UNITS=1).
- Throughput: the first IDLE cycle after the DONE handshake can accept again. There is no overlap between states.
- The block does not combinationally forward out_ready to in_ready.
- busy=1 in G_CALC, COMBINE and DONE.

Decomposition:
- Shared package rabbit_pkg holds:
  - RABBIT_WORDS=8 and WORD_W=32
  - rotate amounts ROT_A=16 and ROT_B=8
  - FSM state encoding: IDLE, G_CALC, COMBINE, DONE
  - a rotl32 function
  - word pack/unpack helpers
- One sub-module, rabbit_g_func: combinational; inputs x[31:0] and c[31:0]; output g[31:0]. Instantiated NUM_G_UNITS times.

Test Plan:
- All-zero x_in and c_in, NUM_G_UNITS=1 -> out_valid at edge N+9; all x_out words 0x00000000.
- Every x_j=0, c_j=1 (u=1, g=1) -> even x_out words 0x00020001, odd words 0x00000102.
- x_j=0xFFFFFFFF, c_j=1 (carry discarded, u=0) -> all x_out 0x00000000. Separately, u=0x00010000 (high half only) gives g=1 -> same result as the previous scenario.
- u=0xFFFFFFFF for all j (g=0xFFFFFFFF):
  - x0 = 0xFFFFFFFD, x1 = 0xFFFFFFFD (same pattern for all words).
  - Repeat with NUM_G_UNITS=2/4/8: identical x_out; latency 5/3/2.
- Hold out_ready=0 for 5 cycles after out_valid -> x_out stable, in_ready=0, in_valid pulses ignored. Then release -> back in IDLE with in_ready=1 one cycle later.
- Assert rst during G_CALC idx=4 -> out_valid stays 0, x_out=0, in_ready=1 after release. A fresh input completes with the correct result.

Source files
------------

// File: rtl/rabbit_pkg.sv
`default_nettype none
// ============================================================================
// rabbit_pkg : shared constants, FSM encoding and word helpers for Rabbit
// Rev 1.0
// ============================================================================
package rabbit_pkg;

   localparam int RABBIT_WORDS = 8;
   localparam int WORD_W       = 32;
   localparam int ROT_A        = 16;
   localparam int ROT_B        = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      G_CALC  = 2'd1,
      COMBINE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // n must lie in 1..31 so neither shift reaches the full word width
   function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] w,
                                                input int unsigned       n);
      return (w << n) | (w >> (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] get_word(input logic [RABBIT_WORDS*WORD_W-1:0] v,
                                                  input logic [2:0]                     j);
      return v[{j, 5'b00000} +: WORD_W];
   endfunction

   function automatic logic [RABBIT_WORDS*WORD_W-1:0] set_word(
      input logic [RABBIT_WORDS*WORD_W-1:0] v,
      input logic [2:0]                     j,
      input logic [WORD_W-1:0]              w);
      logic [RABBIT_WORDS*WORD_W-1:0] r;
      r = v;
      r[{j, 5'b00000} +: WORD_W] = w;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rabbit_g_func.sv
`default_nettype none
// ============================================================================
// rabbit_g_func : g = LSW(u^2) ^ MSW(u^2) with u = (x + c) mod 2^32
// Rev 1.0
// ============================================================================
module rabbit_g_func
   import rabbit_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   input  logic [WORD_W-1:0] c,
   output logic [WORD_W-1:0] g
);

   logic [WORD_W-1:0]   u;
   logic [2*WORD_W-1:0] s;

   assign u = x + c;
   assign s = {{WORD_W{1'b0}}, u} * {{WORD_W{1'b0}}, u};
   assign g = s[WORD_W-1:0] ^ s[2*WORD_W-1:WORD_W];

endmodule
`default_nettype wire

// File: rtl/rabbit_next_state.sv
`default_nettype none
// ============================================================================
// rabbit_next_state : time-multiplexed Rabbit g-function and state combine
// Rev 1.0
// ============================================================================
module rabbit_next_state
   import rabbit_pkg::*;
#(
   parameter int NUM_G_UNITS = 1
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] x_in,
   input  logic [255:0] c_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] x_out,
   output logic         busy
);

   localparam logic [2:0] C_IDX_STEP = 3'(NUM_G_UNITS);
   localparam logic [2:0] C_IDX_LAST = 3'(RABBIT_WORDS - NUM_G_UNITS);

   if (!(NUM_G_UNITS == 1 || NUM_G_UNITS == 2 || NUM_G_UNITS == 4 || NUM_G_UNITS == 8))
   begin : g_bad_num_g_units
      $error("rabbit_next_state: NUM_G_UNITS must be 1, 2, 4 or 8");
   end

   state_t       state_q, state_d;
   logic [2:0]   idx_q, idx_d;
   logic [255:0] x_lat_q, x_lat_d;
   logic [255:0] c_lat_q, c_lat_d;
   logic [255:0] g_q, g_d;
   logic [255:0] x_out_q, x_out_d;
   logic         out_valid_q, out_valid_d;
   logic         in_ready_q, in_ready_d;
   logic         busy_q, busy_d;

   logic [WORD_W-1:0] unit_g [NUM_G_UNITS];
   logic [255:0]      x_comb;

   for (genvar k = 0; k < NUM_G_UNITS; k++) begin : g_unit
      logic [2:0] widx;
      assign widx = idx_q + 3'(k);
      rabbit_g_func u_g_func (
         .x (get_word(x_lat_q, widx)),
         .c (get_word(c_lat_q, widx)),
         .g (unit_g[k])
      );
   end

   // Even words mix two 16-bit-rotated predecessors; odd words one 8-bit rotate plus a plain one
   always_comb begin
      logic [2:0]        jm1, jm2;
      logic [WORD_W-1:0] w;
      x_comb = '0;
      for (int j = 0; j < RABBIT_WORDS; j++) begin
         jm1 = 3'(j) - 3'd1;
         jm2 = 3'(j) - 3'd2;
         if (j % 2 == 0) begin
            w = get_word(g_q, 3'(j)) + rotl32(get_word(g_q, jm1), ROT_A)
                                     + rotl32(get_word(g_q, jm2), ROT_A);
         end else begin
            w = get_word(g_q, 3'(j)) + rotl32(get_word(g_q, jm1), ROT_B)
                                     + get_word(g_q, jm2);
         end
         x_comb = set_word(x_comb, 3'(j), w);
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      x_lat_d     = x_lat_q;
      c_lat_d     = c_lat_q;
      g_d         = g_q;
      x_out_d     = x_out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_lat_d = x_in;
               c_lat_d = c_in;
               idx_d   = '0;
               state_d = G_CALC;
            end
         end
         G_CALC: begin
            for (int k = 0; k < NUM_G_UNITS; k++) begin
               g_d = set_word(g_d, idx_q + 3'(k), unit_g[k]);
            end
            idx_d = idx_q + C_IDX_STEP;
            if (idx_q == C_IDX_LAST) begin
               state_d = COMBINE;
            end
         end
         COMBINE: begin
            x_out_d     = x_comb;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         x_lat_q     <= '0;
         c_lat_q     <= '0;
         g_q         <= '0;
         x_out_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         x_lat_q     <= x_lat_d;
         c_lat_q     <= c_lat_d;
         g_q         <= g_d;
         x_out_q     <= x_out_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign x_out     = x_out_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire
